// File: rtl/div_if.sv
// Request/response bundle between the EX stage and the multi-cycle divider.
// The EX stage is the master; the divider is the slave.
interface div_if #(
  parameter int WIDTH = 32
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div.sv
// Multi-cycle restoring shift-subtract divider (DIV/DIVU), one quotient bit per cycle.
// result_o = {remainder, quotient}; both outputs are registered.
module div #(
  parameter int WIDTH = 32
) (
  input logic  clk,
  input logic  rst,
  div_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
  localparam logic [2*WIDTH-1:0] R_ZERO = {(2*WIDTH){1'b0}};

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   divisor_r;
  logic               neg_quot_r;
  logic               neg_rem_r;
  logic [2*WIDTH-1:0] result_r;
  logic               ready_r;

  logic [WIDTH:0]     trial_s;
  logic [2*WIDTH-1:0] step_s;
  logic [WIDTH-1:0]   quot_s;
  logic [WIDTH-1:0]   rem_s;

  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? twos_neg(v) : v;
  endfunction

  // One restoring step plus the final sign fix-up of the finished quotient/remainder.
  always_comb begin
    // Minuend is the shifted upper half including the bit shifted out of the top,
    // so divisors >= 2^(WIDTH-1) still see the full partial remainder.
    trial_s = acc_r[2*WIDTH-1:WIDTH-1] - {1'b0, divisor_r};
    if (trial_s[WIDTH] == 1'b0) begin
      step_s = {trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end else begin
      step_s = {acc_r[2*WIDTH-2:0], 1'b0};
    end
    if (neg_quot_r) begin
      quot_s = twos_neg(acc_r[WIDTH-1:0]);
    end else begin
      quot_s = acc_r[WIDTH-1:0];
    end
    if (neg_rem_r) begin
      rem_s = twos_neg(acc_r[2*WIDTH-1:WIDTH]);
    end else begin
      rem_s = acc_r[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_FREE;
      cnt_r      <= CNT_ZERO;
      acc_r      <= R_ZERO;
      divisor_r  <= W_ZERO;
      neg_quot_r <= 1'b0;
      neg_rem_r  <= 1'b0;
      result_r   <= R_ZERO;
      ready_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_FREE: begin
          ready_r  <= 1'b0;
          result_r <= R_ZERO;
          if (bus.start_i && !bus.annul_i) begin
            if (bus.opdata2_i == W_ZERO) begin
              state_r <= ST_BYZERO;
            end else begin
              state_r    <= ST_ON;
              cnt_r      <= CNT_ZERO;
              divisor_r  <= abs_val(bus.opdata2_i, bus.signed_div_i);
              acc_r      <= {W_ZERO, abs_val(bus.opdata1_i, bus.signed_div_i)};
              neg_quot_r <= bus.signed_div_i & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
              neg_rem_r  <= bus.signed_div_i & bus.opdata1_i[WIDTH-1];
            end
          end else begin
            state_r <= ST_FREE;
          end
        end
        ST_BYZERO: begin
          state_r  <= ST_END;
          result_r <= R_ZERO;
          ready_r  <= 1'b1;
        end
        ST_ON: begin
          // A flush beats completion on the same edge.
          if (bus.annul_i) begin
            state_r  <= ST_FREE;
            ready_r  <= 1'b0;
            result_r <= R_ZERO;
          end else if (cnt_r != CNT_DONE) begin
            acc_r <= step_s;
            cnt_r <= cnt_r + CNT_ONE;
          end else begin
            state_r  <= ST_END;
            result_r <= {rem_s, quot_s};
            ready_r  <= 1'b1;
          end
        end
        ST_END: begin
          if (!bus.start_i) begin
            state_r  <= ST_FREE;
            ready_r  <= 1'b0;
            result_r <= R_ZERO;
          end else begin
            state_r <= ST_END;
          end
        end
        default: begin
          state_r  <= ST_FREE;
          ready_r  <= 1'b0;
          result_r <= R_ZERO;
        end
      endcase
    end
  end

  assign bus.result_o = result_r;
  assign bus.ready_o  = ready_r;
endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: the driver queues hand-computed results, the monitor
// pops and compares on each rising ready_o, including the start-to-ready latency.
module tb_div;
  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fails;
  logic ready_prev;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          t0;
  } exp_t;

  exp_t exp_q[$];

  div_if #(.WIDTH(32)) bus ();

  div #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: compare on every rising edge of ready_o.
  always @(negedge clk) begin
    if (bus.ready_o && !ready_prev) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_ready: ready_o rose with result 0x%0h and nothing expected", bus.result_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", bus.result_o, e.res);
        check("latency", 64'(cyc - e.t0), 64'(e.lat));
      end
    end
    ready_prev = bus.ready_o;
  end

  // Issue one division from a negedge; mode 0 drops start, 1 holds it while
  // changing operands, 2 resets while in END.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input int lat, input int mode);
    exp_t e;
    int   waited;
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    e.res = {er, eq};
    e.lat = lat;
    e.t0  = cyc;
    exp_q.push_back(e);
    waited = 0;
    while (!bus.ready_o && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("ready_seen", 64'(bus.ready_o), 64'd1);
    if (mode == 1) begin
      for (int i = 0; i < 5; i++) begin
        bus.opdata1_i    = a + 32'(i) + 32'd1;
        bus.opdata2_i    = 32'd3 + 32'(i);
        bus.signed_div_i = ~sgn;
        @(negedge clk);
        check("hold_ready", 64'(bus.ready_o), 64'd1);
        check("hold_result", bus.result_o, e.res);
      end
    end
    if (mode == 2) begin
      rst         = 1'b1;
      bus.start_i = 1'b0;
      @(negedge clk);
      check("rst_end_ready", 64'(bus.ready_o), 64'd0);
      check("rst_end_result", bus.result_o, 64'd0);
      rst = 1'b0;
    end else begin
      bus.start_i = 1'b0;
      @(negedge clk);
      check("drop_ready", 64'(bus.ready_o), 64'd0);
      check("drop_result", bus.result_o, 64'd0);
    end
  endtask

  initial begin
    cyc          = 0;
    n_checks     = 0;
    n_fails      = 0;
    ready_prev   = 1'b0;
    rst          = 1'b1;
    bus.start_i  = 1'b0;
    bus.annul_i  = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd0;
    bus.opdata2_i    = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_ready", 64'(bus.ready_o), 64'd0);
    check("reset_result", bus.result_o, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_div(1'b0, 32'd100,        32'd7,        32'h0000000E, 32'h00000002, 34, 0);
    run_div(1'b1, 32'hFFFFFFF9,   32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 34, 0);
    run_div(1'b1, 32'h00000007,   32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 34, 0);
    run_div(1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'h0000000E, 32'hFFFFFFFE, 34, 0);
    run_div(1'b0, 32'h12345678,   32'h00000000, 32'h00000000, 32'h00000000, 2,  0);
    run_div(1'b1, 32'h80000000,   32'h00000000, 32'h00000000, 32'h00000000, 2,  0);
    run_div(1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'h00000000, 34, 0);
    run_div(1'b0, 32'hFFFFFFFF,   32'h80000001, 32'h00000001, 32'h7FFFFFFE, 34, 0);
    run_div(1'b0, 32'hFFFFFFFF,   32'h00000001, 32'hFFFFFFFF, 32'h00000000, 34, 0);
    run_div(1'b0, 32'd5,          32'd9,        32'h00000000, 32'h00000005, 34, 0);

    // Flush mid-division, then restart straight away.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'hFFFFFFFF;
    bus.opdata2_i    = 32'h00000001;
    bus.start_i      = 1'b1;
    repeat (10) @(negedge clk);
    bus.annul_i = 1'b1;
    @(negedge clk);
    bus.annul_i = 1'b0;
    check("annul_ready", 64'(bus.ready_o), 64'd0);
    run_div(1'b0, 32'd9, 32'd3, 32'h00000003, 32'h00000000, 34, 0);

    // Reset in the middle of a division.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    repeat (20) @(negedge clk);
    rst         = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    check("rst_on_ready", 64'(bus.ready_o), 64'd0);
    check("rst_on_result", bus.result_o, 64'd0);
    rst = 1'b0;
    run_div(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 34, 0);

    // Reset while in END, then a normal division.
    run_div(1'b0, 32'd50, 32'd6, 32'd8, 32'd2, 34, 2);
    run_div(1'b1, 32'hFFFFFFCE, 32'd6, 32'hFFFFFFF8, 32'hFFFFFFFE, 34, 0);

    // Start held in END with changing operands.
    run_div(1'b0, 32'd77, 32'd10, 32'd7, 32'd7, 34, 1);

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d, expected completion earlier", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/div.md
# div

Multi-cycle 32-bit integer divider (signed and unsigned) in the EX stage. It is the responder on the EX-side stall path. The EX stage raises `start_i` for DIV/DIVU and holds `stallreq_from_ex` until `ready_o`, which freezes the ID/EX register through `stall[2]`. It produces the quotient and remainder destined for HI/LO using restoring shift-subtract, one quotient bit per cycle.

## Interface
- `WIDTH`, 32: operand width. `result_o` is 2*`WIDTH`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `signed_div_i`  in  1  1 = DIV (two's complement), 0 = DIVU.
- `opdata1_i`  in  WIDTH  dividend.
- `opdata2_i`  in  WIDTH  divisor.
- `start_i`  in  1  request. Held high by EX until `ready_o` is seen, then dropped.
- `annul_i`  in  1  abort the in-flight division (branch/exception flush).
- `result_o`  out  2*WIDTH  {remainder[63:32], quotient[31:0]}, registered.
- `ready_o`  out  1  result valid, registered.

## Operation
- States: FREE, BYZERO, ON, END. Reset state is FREE, with `result_o`=0, `ready_o`=0, and the iteration counter at 0.
- FREE
  - `start_i`=1 and `annul_i`=0 with `opdata2_i`=0: go to BYZERO.
  - `start_i`=1 and `annul_i`=0 with `opdata2_i`≠0: go to ON.
    - Latch operands. When signed, latch absolute values and record the sign of each operand.
    - Clear the counter and load the 64-bit partial-remainder register with {32'b0, |dividend|}.
  - Otherwise stay in FREE with `ready_o`=0 and `result_o`=0.
- BYZERO: the next edge goes to END with the result forced to 0.
- ON, with `annul_i`=1: go to FREE at once. `ready_o` stays 0 and the partial result is discarded.
- ON, counter < 32: do one restoring step per edge, then increment the counter.
  - Shift the register left 1.
  - Form the 33-bit trial = upper 32 bits − |divisor|.
  - If trial ≥ 0, replace the upper half with the trial and set quotient LSB = 1; otherwise set quotient LSB = 0.
- ON, counter = 32: apply the sign fix-up, load `result_o`, set `ready_o`=1, go to END.
  - Signed only: negate the quotient if the operand signs differ; negate the remainder if the dividend was negative.
- END: hold `result_o` and `ready_o`=1 while `start_i`=1. When `start_i`=0, go to FREE and clear `ready_o` and `result_o` on that edge.
- Operand changes after the start edge are ignored. `start_i` in ON, BYZERO or END is not a new request.
- Arithmetic:
  - Subtraction is 33-bit; its MSB is the borrow/negative flag.
  - Negation is two's complement mod 2^32.
  - Signed 0x80000000 / 0xFFFFFFFF wraps: quotient 0x80000000, remainder 0.
- `annul_i` in FREE, BYZERO or END has no effect beyond blocking a start in FREE.

## Timing
- Edge E0 samples `start_i` in FREE.
- Nonzero divisor: 32 iteration edges E1..E32, then E33 sets `ready_o`. `ready_o` is first high in the cycle after E33, i.e. 34 cycles after the start is first presented.
- Divide by zero: `ready_o` is high in the cycle after E1.
- The result is stable for as long as `ready_o`=1. EX captures it in the first ready cycle and drops `start_i`. The block is back in FREE one edge later and can accept a new start on the following edge.
- `rst`=1 on any edge, including mid-ON or END, forces FREE with all outputs 0 on that edge. `rst` takes priority over `annul_i` and `start_i`.
- `annul_i` and the counter reaching 32 on the same edge: annul wins and there is no `ready_o`.

## Test plan
- DIVU 100 / 7: `ready_o` rises 34 cycles after start; `result_o` = {0x00000002, 0x0000000E}. Drop `start_i` → `ready_o`=0 next cycle.
- DIV −7 / 2 (0xFFFFFFF9 / 0x00000002): quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 7 / −2: quotient 0xFFFFFFFD, remainder 0x00000001.
- DIVU 0x12345678 / 0: `ready_o` after 2 cycles, `result_o`=0. Signed 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}.
- Start 0xFFFFFFFF / 1 unsigned, pulse `annul_i` on cycle 10: FREE next edge, `ready_o` never asserts. An immediate new start of 9 / 3 then gives quotient 3, remainder 0 on schedule.
- Assert `rst` at cycle 20 of a division and again while in END: all outputs 0 on the next cycle. A following start completes normally.
- Hold `start_i` high 5 extra cycles in END while changing the operands: `result_o` and `ready_o` stay unchanged and no restart occurs.
